// File: rtl/pipe_pkg.sv
// Shared constants and boundary bundle types for the inter-stage pipeline registers.
package pipe_pkg;

  localparam int unsigned DEF_CTRL_W  = 8;
  localparam int unsigned DEF_DATA_W  = 96;
  localparam int unsigned DEF_CNT_W   = 16;

  localparam int unsigned IFID_CTRL_W  = 8;
  localparam int unsigned IFID_DATA_W  = 64;
  localparam int unsigned IDEX_CTRL_W  = 8;
  localparam int unsigned IDEX_DATA_W  = 96;
  localparam int unsigned EXMEM_CTRL_W = 8;
  localparam int unsigned EXMEM_DATA_W = 96;
  localparam int unsigned MEMWB_CTRL_W = 8;
  localparam int unsigned MEMWB_DATA_W = 64;

  // Write-back data source select
  typedef enum logic [1:0] {
    WD_ALU = 2'd0,
    WD_MEM = 2'd1,
    WD_PC4 = 2'd2,
    WD_IMM = 2'd3
  } wd_sel_e;

  typedef struct packed {
    logic       pred_taken;
    logic [6:0] rsvd;
  } ifid_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } ifid_data_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    wd_sel_e    wd_sel;
    logic [2:0] alu_op;
  } idex_ctrl_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] op_a;
    logic [31:0] op_b;
  } idex_data_t;

  typedef struct packed {
    logic       reg_we;
    logic       mem_we;
    logic       mem_re;
    wd_sel_e    wd_sel;
    logic [2:0] mem_size;
  } exmem_ctrl_t;

  typedef struct packed {
    logic [31:0] pc_plus4;
    logic [31:0] alu_res;
    logic [31:0] store_data;
  } exmem_data_t;

  typedef struct packed {
    logic       reg_we;
    wd_sel_e    wd_sel;
    logic [4:0] rd;
  } memwb_ctrl_t;

  typedef struct packed {
    logic [31:0] alu_res;
    logic [31:0] load_data;
  } memwb_data_t;

endpackage

// File: rtl/pipe_skid_buf.sv
// One-entry skid register that parks a beat accepted while the main stage register stalls.
module pipe_skid_buf
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush_i,
  input  logic              push_i,
  input  logic              pop_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;

  // Push only happens while empty, so push and pop never coincide.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (push_i) begin
      valid_d = 1'b1;
      ctrl_d  = ctrl_i;
      data_d  = data_i;
    end else if (pop_i) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else begin
      valid_d = valid_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign data_o  = data_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with valid/ready, flush, saturating stall counter.
// Optional skid entry enabled by defining PIPE_STAGE_SKID_EN.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int unsigned CTRL_W = DEF_CTRL_W,
  parameter int unsigned DATA_W = DEF_DATA_W,
  parameter int unsigned CNT_W  = DEF_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt
);

  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  logic              main_open_s;
  logic              src_valid_s;
  logic [CTRL_W-1:0] src_ctrl_s;
  logic [DATA_W-1:0] src_data_s;

  assign main_open_s = ~valid_q | out_ready;

`ifdef PIPE_STAGE_SKID_EN
  logic              in_fire_s;
  logic              skid_valid_s;
  logic [CTRL_W-1:0] skid_ctrl_s;
  logic [DATA_W-1:0] skid_data_s;

  assign in_ready  = ~skid_valid_s;
  assign in_fire_s = in_valid & in_ready;

  pipe_skid_buf #(
    .CTRL_W (CTRL_W),
    .DATA_W (DATA_W)
  ) u_skid (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush_i (flush),
    .push_i  (in_fire_s & ~main_open_s),
    .pop_i   (skid_valid_s & main_open_s),
    .ctrl_i  (in_ctrl),
    .data_i  (in_data),
    .valid_o (skid_valid_s),
    .ctrl_o  (skid_ctrl_s),
    .data_o  (skid_data_s)
  );

  // A parked beat is older than anything upstream, so it refills main first.
  always_comb begin
    src_valid_s = in_fire_s;
    src_ctrl_s  = in_ctrl;
    src_data_s  = in_data;
    if (skid_valid_s) begin
      src_valid_s = 1'b1;
      src_ctrl_s  = skid_ctrl_s;
      src_data_s  = skid_data_s;
    end else begin
      src_valid_s = in_fire_s;
    end
  end
`else
  assign in_ready    = main_open_s;
  assign src_valid_s = in_valid;
  assign src_ctrl_s  = in_ctrl;
  assign src_data_s  = in_data;
`endif

  // Data is only ever replaced by a new beat; control drops to zero with valid.
  always_comb begin
    valid_d = valid_q;
    ctrl_d  = ctrl_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
      ctrl_d  = '0;
    end else if (main_open_s) begin
      valid_d = src_valid_s;
      if (src_valid_s) begin
        ctrl_d = src_ctrl_s;
        data_d = src_data_s;
      end else begin
        ctrl_d = '0;
      end
    end else begin
      valid_d = valid_q;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    if (valid_q && !out_ready && !(&cnt_q)) begin
      cnt_d = cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end else begin
      cnt_d = cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ctrl_q  <= ctrl_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  assign out_valid = valid_q;
  assign out_ctrl  = ctrl_q;
  assign out_data  = data_q;
  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Scoreboard bench for pipe_stage_reg; a second instance with a 4-bit stall counter checks saturation.
module tb_pipe_stage_reg;

  typedef struct packed {
    logic [7:0]  c;
    logic [95:0] d;
  } beat_t;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        in_valid;
  logic        out_ready;
  logic [7:0]  in_ctrl;
  logic [95:0] in_data;
  logic        in_ready, out_valid;
  logic [7:0]  out_ctrl;
  logic [95:0] out_data;
  logic [15:0] stall_cnt;
  logic        in_ready_b, out_valid_b;
  logic [7:0]  out_ctrl_b;
  logic [95:0] out_data_b;
  logic [3:0]  stall_cnt_b;

  beat_t sb_q[$];
  beat_t exp_b;
  int    n_tests = 0;
  int    n_fail  = 0;
  int    push_cnt = 0;
  int    pop_cnt  = 0;
  int    base, p0, k;
  logic  exp_rdy;

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_ctrl(out_ctrl), .out_data(out_data), .stall_cnt(stall_cnt)
  );

  pipe_stage_reg #(.CTRL_W(8), .DATA_W(96), .CNT_W(4)) dut_c4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready_b),
    .in_ctrl(in_ctrl), .in_data(in_data), .out_valid(out_valid_b), .out_ready(out_ready),
    .out_ctrl(out_ctrl_b), .out_data(out_data_b), .stall_cnt(stall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_beat(input int idx);
    in_ctrl = idx[7:0] ^ 8'h3C;
    in_data = {idx[31:0] + 32'hBEEF0000, ~idx[31:0], idx[31:0] * 32'd7};
  endtask

  // Stimulus side of the scoreboard: record every accepted, non-flushed beat.
  always @(negedge clk) begin
    if (rst_n && !flush && in_valid && in_ready) begin
      sb_q.push_back({in_ctrl, in_data});
      push_cnt++;
    end
  end

  // Monitor: every output transfer must match the oldest outstanding beat.
  always @(negedge clk) begin
    if (!rst_n) begin
      sb_q.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL sb_unexpected: got beat %0h expected none", {out_ctrl, out_data});
        end else begin
          exp_b = sb_q.pop_front();
          check("sb_beat", {out_ctrl, out_data}, exp_b);
          pop_cnt++;
        end
      end
      if (!out_valid) check("ctrl_zero_idle", out_ctrl, 128'd0);
      if (flush) sb_q.delete();
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_ctrl = 8'h00; in_data = 96'h0;
    repeat (3) cyc();
    check("rst_valid", out_valid, 128'd0);
    check("rst_ctrl", out_ctrl, 128'd0);
    check("rst_data", out_data, 128'd0);
    check("rst_cnt", stall_cnt, 128'd0);
    check("rst_ready", in_ready, 128'd1);
    rst_n = 1'b1;

    // single beat, one-cycle latency
    in_valid = 1'b1; in_ctrl = 8'hA5; in_data = 96'h1234; out_ready = 1'b1;
    cyc();
    check("t1_valid", out_valid, 128'd1);
    check("t1_ctrl", out_ctrl, 128'hA5);
    check("t1_data", out_data, 128'h1234);
    check("t1_cnt", stall_cnt, 128'd0);

    // five-cycle stall with a second beat waiting
    out_ready = 1'b0; in_ctrl = 8'h5A; in_data = 96'h5678;
    for (int i = 0; i < 5; i++) begin
      cyc();
      check("t2_hold", {out_valid, out_ctrl, out_data}, {1'b1, 8'hA5, 96'h1234});
    end
    check("t2_cnt", stall_cnt, 128'd5);
    check("t2_ready_stall", in_ready, 128'd0);
    out_ready = 1'b1;
    #1;
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = 1'b0;
`else
    exp_rdy = 1'b1;
`endif
    check("t2_ready_path", in_ready, {127'd0, exp_rdy});
    cyc();
    check("t2_second", {out_valid, out_ctrl, out_data}, {1'b1, 8'h5A, 96'h5678});
    in_valid = 1'b0;
    cyc();
    check("t2_bubble", {out_valid, out_ctrl, out_data}, {1'b0, 8'h00, 96'h5678});

    // flush kills the stored and the incoming beat
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h11; in_data = 96'hAAAA;
    cyc();
    check("t3_load", {out_valid, out_ctrl}, {1'b1, 8'h11});
    flush = 1'b1; in_ctrl = 8'h22; in_data = 96'hBBBB;
    cyc();
    check("t3_flush", {out_valid, out_ctrl, out_data}, {1'b0, 8'h00, 96'hAAAA});
    check("t3_ready", in_ready, 128'd1);
    check("t3_cnt", stall_cnt, 128'd6);
    flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    repeat (3) cyc();
    check("t3_no_replay", out_valid, 128'd0);

    // flush together with out_ready: the presented beat still transfers
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h33; in_data = 96'hCCCC;
    cyc();
    p0 = pop_cnt;
    out_ready = 1'b1; flush = 1'b1; in_ctrl = 8'h44; in_data = 96'hDDDD;
    cyc();
    check("t3b_xfer", pop_cnt - p0, 128'd1);
    check("t3b_valid", {out_valid, out_ctrl}, {1'b0, 8'h00});
    flush = 1'b0; in_valid = 1'b0;
    repeat (2) cyc();

    // 20-cycle permanent stall: 16-bit keeps counting, 4-bit saturates
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h55; in_data = 96'hEEEE;
    cyc();
    in_valid = 1'b0;
    repeat (20) cyc();
    check("t4_cnt16", stall_cnt, 128'd26);
    check("t4_cnt4_sat", stall_cnt_b, 128'hF);
    check("t4_c4_hold", {out_valid_b, out_ctrl_b, out_data_b}, {1'b1, 8'h55, 96'hEEEE});
`ifdef PIPE_STAGE_SKID_EN
    exp_rdy = 1'b1;
`else
    exp_rdy = 1'b0;
`endif
    check("t4_c4_ready", in_ready_b, {127'd0, exp_rdy});
    out_ready = 1'b1;
    cyc();
    check("t4_drain", out_valid, 128'd0);

    // 100-beat random stream
    base = push_cnt; p0 = pop_cnt;
    for (int c = 0; c < 3000 && (push_cnt - base) < 100; c++) begin
      k = push_cnt - base;
      set_beat(k);
      in_valid  = 1'($urandom_range(0, 1));
      out_ready = 1'($urandom_range(0, 1));
      cyc();
    end
    check("t5_all_sent", push_cnt - base, 128'd100);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (6) cyc();
    check("t5_all_recv", pop_cnt - p0, 128'd100);
    check("t5_sb_empty", sb_q.size(), 128'd0);

    // alternating out_ready: one beat every two cycles
    p0 = pop_cnt; base = push_cnt;
    in_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      set_beat(1000 + push_cnt - base);
      out_ready = (i % 2) == 1;
      cyc();
    end
    check("t5_thru", pop_cnt - p0, 128'd10);
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (4) cyc();
    check("t5_thru_empty", sb_q.size(), 128'd0);

    // reset pulse while stalled with a waiting beat
    out_ready = 1'b0; in_valid = 1'b1; in_ctrl = 8'h66; in_data = 96'h6666;
    cyc();
    in_ctrl = 8'h77; in_data = 96'h7777;
    cyc();
    rst_n = 1'b0;
    #1;
    check("t6_valid", {out_valid, out_ctrl}, {1'b0, 8'h00});
    check("t6_cnt", stall_cnt, 128'd0);
    check("t6_ready", in_ready, 128'd1);
    in_valid = 1'b0;
    repeat (2) cyc();
    rst_n = 1'b1; out_ready = 1'b1;
    p0 = pop_cnt;
    repeat (5) cyc();
    check("t6_no_replay", {out_valid, out_data}, {1'b0, 96'h0});
    check("t6_no_pop", pop_cnt - p0, 128'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
